adsr_voice_sched: RTL and testbench

- Time-multiplexes one combinational adsr_mngt2 envelope engine across NB_VOICE polyphonic voices.
- Holds per-voice envelope context: state, volume, pressed/released flags.
- Latches note-on/off events from the MIDI decoder.
- On every envelope tick, sweeps all voices through the engine and writes results back.
- Emits one registered volume word per voice to the mixer.

---
 rtl/adsr_voice_sched_if.sv | 26 ++
 rtl/adsr_voice_sched.sv | 192 +++++++++++++++++++
 tb/tb_adsr_voice_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adsr_voice_sched_if.sv
// Bus between the voice scheduler and the shared combinational ADSR engine.
//   eng_state/eng_volume/eng_note_pressed/eng_note_released : engine inputs (scheduler drives)
//   eng_o_*                                                  : engine outputs (engine drives)
// Modports: master = scheduler side, slave = engine side.
interface adsr_voice_sched_if #(
    parameter int unsigned VOL_W = 18
);
    logic [2:0]       eng_state;
    logic [VOL_W-1:0] eng_volume;
    logic             eng_note_pressed;
    logic             eng_note_released;
    logic [2:0]       eng_o_state;
    logic [VOL_W-1:0] eng_o_volume;
    logic             eng_o_note_pressed;
    logic             eng_o_note_released;

    modport master (
        output eng_state, eng_volume, eng_note_pressed, eng_note_released,
        input  eng_o_state, eng_o_volume, eng_o_note_pressed, eng_o_note_released
    );

    modport slave (
        input  eng_state, eng_volume, eng_note_pressed, eng_note_released,
        output eng_o_state, eng_o_volume, eng_o_note_pressed, eng_o_note_released
    );
endinterface

// File: rtl/adsr_voice_sched.sv
// Polyphonic ADSR scheduler: time-multiplexes one combinational envelope engine across
// NB_VOICE voices. Per-voice context (state, volume, pressed/released) lives here; note
// events are latched as pending bits and folded into the next sweep of that voice.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   note_on_*/note_off_*    : one-cycle note event strobes with target voice
//   eng                     : engine bus (registered engine inputs, combinational outputs)
//   sweep_start             : one-cycle pulse when a sweep is launched
//   vol_valid/voice/out     : per-voice updated volume, one strobe per voice per sweep
//   tick_overrun            : sticky flag, a tick expired while a sweep was running
module adsr_voice_sched #(
    parameter int unsigned NB_VOICE = 16,
    parameter int unsigned VOICE_W  = 4,
    parameter int unsigned VOL_W    = 18,
    parameter int unsigned TICK_DIV = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      note_on_valid,
    input  logic [VOICE_W-1:0]        note_on_voice,
    input  logic                      note_off_valid,
    input  logic [VOICE_W-1:0]        note_off_voice,
    adsr_voice_sched_if.master        eng,
    output logic                      sweep_start,
    output logic                      vol_valid,
    output logic [VOICE_W-1:0]        vol_voice,
    output logic [VOL_W-1:0]          vol_out,
    output logic                      tick_overrun
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TickReload = CNT_W'(TICK_DIV - 1);
    localparam logic [VOICE_W-1:0] LastVoice = VOICE_W'(NB_VOICE - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StStore} state_e;

    state_e               state_q, state_d;
    logic [VOICE_W-1:0]   vidx_q, vidx_d;
    logic [CNT_W-1:0]     tick_cnt_q;
    logic                 tick;
    logic                 overrun_q;
    logic                 load_en, store_en;

    logic [NB_VOICE-1:0]  pend_press_q, pend_press_d;
    logic [NB_VOICE-1:0]  pend_rel_q, pend_rel_d;

    logic [2:0]           ctx_state_q [NB_VOICE];
    logic [VOL_W-1:0]     ctx_vol_q   [NB_VOICE];
    logic [NB_VOICE-1:0]  ctx_press_q;
    logic [NB_VOICE-1:0]  ctx_rel_q;

    logic [2:0]           eng_state_q;
    logic [VOL_W-1:0]     eng_volume_q;
    logic                 eng_press_q, eng_rel_q;

    logic                 vol_valid_q;
    logic [VOICE_W-1:0]   vol_voice_q;
    logic [VOL_W-1:0]     vol_out_q;

    assign tick = (tick_cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= TickReload;
            overrun_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? TickReload : tick_cnt_q - 1'b1;
            // A tick that cannot launch a sweep is dropped and remembered.
            if (tick && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        vidx_d      = vidx_q;
        sweep_start = 1'b0;
        load_en     = 1'b0;
        store_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    sweep_start = 1'b1;
                    vidx_d      = '0;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                load_en = 1'b1;
                state_d = StStore;
            end
            StStore: begin
                store_en = 1'b1;
                if (vidx_q == LastVoice) begin
                    state_d = StIdle;
                end else begin
                    vidx_d  = vidx_q + 1'b1;
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Consumption clears the loaded voice first; a strobe landing in the same cycle then
    // re-sets its bit so the event survives to the next sweep.
    always_comb begin
        pend_press_d = pend_press_q;
        pend_rel_d   = pend_rel_q;
        if (load_en) begin
            pend_press_d[vidx_q] = 1'b0;
            pend_rel_d[vidx_q]   = 1'b0;
        end
        if (note_on_valid) begin
            pend_press_d[note_on_voice] = 1'b1;
        end
        if (note_off_valid) begin
            pend_rel_d[note_off_voice] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vidx_q       <= '0;
            pend_press_q <= '0;
            pend_rel_q   <= '0;
        end else begin
            state_q      <= state_d;
            vidx_q       <= vidx_d;
            pend_press_q <= pend_press_d;
            pend_rel_q   <= pend_rel_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB_VOICE; i++) begin
                ctx_state_q[i] <= '0;
                ctx_vol_q[i]   <= '0;
            end
            ctx_press_q <= '0;
            ctx_rel_q   <= '0;
        end else if (store_en) begin
            ctx_state_q[vidx_q] <= eng.eng_o_state;
            ctx_vol_q[vidx_q]   <= eng.eng_o_volume;
            ctx_press_q[vidx_q] <= eng.eng_o_note_pressed;
            ctx_rel_q[vidx_q]   <= eng.eng_o_note_released;
        end
    end

    // Engine inputs are registered so the engine settles during the following STORE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_state_q  <= '0;
            eng_volume_q <= '0;
            eng_press_q  <= 1'b0;
            eng_rel_q    <= 1'b0;
        end else if (load_en) begin
            eng_state_q  <= ctx_state_q[vidx_q];
            eng_volume_q <= ctx_vol_q[vidx_q];
            eng_press_q  <= ctx_press_q[vidx_q] | pend_press_q[vidx_q];
            eng_rel_q    <= ctx_rel_q[vidx_q] | pend_rel_q[vidx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_valid_q <= 1'b0;
            vol_voice_q <= '0;
            vol_out_q   <= '0;
        end else begin
            vol_valid_q <= store_en;
            if (store_en) begin
                vol_voice_q <= vidx_q;
                vol_out_q   <= eng.eng_o_volume;
            end
        end
    end

    assign eng.eng_state         = eng_state_q;
    assign eng.eng_volume        = eng_volume_q;
    assign eng.eng_note_pressed  = eng_press_q;
    assign eng.eng_note_released = eng_rel_q;

    assign vol_valid    = vol_valid_q;
    assign vol_voice    = vol_voice_q;
    assign vol_out      = vol_out_q;
    assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_adsr_voice_sched.sv
// Bench for adsr_voice_sched: scoreboard of expected per-voice results pushed at each sweep
// start and popped on vol_valid. Instance a (TICK_DIV=40) carries the note tests; instance b
// (TICK_DIV=20) exercises tick overrun. Engine is a loopback stub: volume+1 when pressed.
module tb_adsr_voice_sched;
    localparam int unsigned NV   = 16;
    localparam int unsigned VW   = 4;
    localparam int unsigned VOLW = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          on_v, off_v;
    logic [VW-1:0] on_voice, off_voice;

    logic            ss_a, vv_a, ov_a, ss_b, vv_b, ov_b;
    logic [VW-1:0]   vvoice_a, vvoice_b;
    logic [VOLW-1:0] vout_a, vout_b;

    adsr_voice_sched_if #(.VOL_W(VOLW)) ifa ();
    adsr_voice_sched_if #(.VOL_W(VOLW)) ifb ();

    assign ifa.eng_o_state         = ifa.eng_state;
    assign ifa.eng_o_volume        = ifa.eng_note_pressed ? ifa.eng_volume + 18'd1 : ifa.eng_volume;
    assign ifa.eng_o_note_pressed  = 1'b0;
    assign ifa.eng_o_note_released = 1'b0;
    assign ifb.eng_o_state         = ifb.eng_state;
    assign ifb.eng_o_volume        = ifb.eng_note_pressed ? ifb.eng_volume + 18'd1 : ifb.eng_volume;
    assign ifb.eng_o_note_pressed  = 1'b0;
    assign ifb.eng_o_note_released = 1'b0;

    adsr_voice_sched #(.NB_VOICE(NV), .VOICE_W(VW), .VOL_W(VOLW), .TICK_DIV(40)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .note_on_valid  (on_v),
        .note_on_voice  (on_voice),
        .note_off_valid (off_v),
        .note_off_voice (off_voice),
        .eng            (ifa),
        .sweep_start    (ss_a),
        .vol_valid      (vv_a),
        .vol_voice      (vvoice_a),
        .vol_out        (vout_a),
        .tick_overrun   (ov_a)
    );

    adsr_voice_sched #(.NB_VOICE(NV), .VOICE_W(VW), .VOL_W(VOLW), .TICK_DIV(20)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .note_on_valid  (1'b0),
        .note_on_voice  (4'd0),
        .note_off_valid (1'b0),
        .note_off_voice (4'd0),
        .eng            (ifb),
        .sweep_start    (ss_b),
        .vol_valid      (vv_b),
        .vol_voice      (vvoice_b),
        .vol_out        (vout_b),
        .tick_overrun   (ov_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int              cyc;
        logic [VW-1:0]   voice;
        logic [VOLW-1:0] vol;
        logic            pr;
        logic            rl;
    } exp_t;

    exp_t            q[$];
    logic [VOLW-1:0] m_vol [NV];
    bit              m_pp  [NV];
    bit              m_pr  [NV];
    int              ss_cnt = 0, ss0 = 0, ss1 = 0, last_ss = 0;
    int              done_a = 0, done_b = 0;
    logic [VW-1:0]   b_next = '0;

    // Scoreboard for instance a.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ss_a) begin
                if (ss_cnt == 0) ss0 = cyc;
                else if (ss_cnt == 1) ss1 = cyc;
                last_ss = cyc;
                ss_cnt++;
                for (int v = 0; v < NV; v++) begin
                    exp_t e;
                    e.cyc   = cyc + 3 + 2 * v;
                    e.voice = VW'(v);
                    e.vol   = m_vol[v] + (m_pp[v] ? 18'd1 : 18'd0);
                    e.pr    = m_pp[v];
                    e.rl    = m_pr[v];
                    q.push_back(e);
                    m_vol[v] = e.vol;
                    m_pp[v]  = 1'b0;
                    m_pr[v]  = 1'b0;
                end
            end
            if (vv_a) begin
                if (q.size() == 0) begin
                    chk("vol_valid_unexpected", 32'(vv_a), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("vol_valid_cycle", cyc, e.cyc);
                    chk("vol_voice", 32'(vvoice_a), 32'(e.voice));
                    chk("vol_out", 32'(vout_a), 32'(e.vol));
                    chk("eng_note_pressed", 32'(ifa.eng_note_pressed), 32'(e.pr));
                    chk("eng_note_released", 32'(ifa.eng_note_released), 32'(e.rl));
                    if (e.voice == 4'd15) done_a++;
                end
            end
        end
    end

    // Instance b: every sweep must cover all voices in order with zero volume.
    always @(negedge clk) begin
        if (rst_n && vv_b) begin
            chk("b_vol_voice", 32'(vvoice_b), 32'(b_next));
            chk("b_vol_out", 32'(vout_b), 32'd0);
            b_next = b_next + 1'b1;
            if (vvoice_b == 4'd15) done_b++;
        end
    end

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_a < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done_a >= target), 32'd1);
    endtask

    task automatic wait_sweep_start();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ss_a && n < 100);
        chk("sweep_start_seen", 32'(ss_a), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cyc;
        int tgt;
        on_v = 1'b0; off_v = 1'b0; on_voice = '0; off_voice = '0;
        for (int v = 0; v < NV; v++) begin
            m_vol[v] = '0; m_pp[v] = 1'b0; m_pr[v] = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk("rst_sweep_start", 32'(ss_a), 32'd0);
        chk("rst_vol_valid", 32'(vv_a), 32'd0);
        chk("rst_vol_voice", 32'(vvoice_a), 32'd0);
        chk("rst_vol_out", 32'(vout_a), 32'd0);
        chk("rst_overrun", 32'(ov_a), 32'd0);
        chk("rst_eng_state", 32'(ifa.eng_state), 32'd0);
        chk("rst_eng_volume", 32'(ifa.eng_volume), 32'd0);
        chk("rst_eng_flags", {30'd0, ifa.eng_note_pressed, ifa.eng_note_released}, 32'd0);
        chk("rst_b_overrun", 32'(ov_b), 32'd0);
        rst_n = 1'b1;
        rel_cyc = cyc;

        // Idle sweeps: timing and all-zero volumes.
        wait_done(1, "sweep1_done");
        wait_done(2, "sweep2_done");
        chk("first_sweep_cycle", ss0 - rel_cyc, 32'd39);
        chk("sweep_period", ss1 - ss0, 32'd40);
        chk("a_no_overrun", 32'(ov_a), 32'd0);
        chk("b_overrun_set", 32'(ov_b), 32'd1);
        chk("b_sweep_complete", 32'(done_b >= 1), 32'd1);

        // Note-on voice 5 between sweeps.
        on_v = 1'b1; on_voice = 4'd5; m_pp[5] = 1'b1;
        @(negedge clk);
        on_v = 1'b0;
        wait_done(3, "sweep3_done");
        wait_done(4, "sweep4_done");

        // Note-on voice 3 during its own LOAD cycle: held over to the next sweep.
        wait_sweep_start();
        repeat (7) @(negedge clk);
        on_v = 1'b1; on_voice = 4'd3; m_pp[3] = 1'b1;
        @(negedge clk);
        on_v = 1'b0;
        wait_done(5, "sweep5_done");
        wait_done(6, "sweep6_done");

        // Simultaneous note-on and note-off to voice 7.
        on_v = 1'b1; on_voice = 4'd7; off_v = 1'b1; off_voice = 4'd7;
        m_pp[7] = 1'b1; m_pr[7] = 1'b1;
        @(negedge clk);
        on_v = 1'b0; off_v = 1'b0;
        wait_done(7, "sweep7_done");
        wait_done(8, "sweep8_done");
        chk("b_overrun_sticky", 32'(ov_b), 32'd1);

        // Reset at T+10 of a sweep with nonzero contexts.
        wait_sweep_start();
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_sweep_start", 32'(ss_a), 32'd0);
        chk("mid_rst_vol_valid", 32'(vv_a), 32'd0);
        chk("mid_rst_vol_voice", 32'(vvoice_a), 32'd0);
        chk("mid_rst_vol_out", 32'(vout_a), 32'd0);
        chk("mid_rst_eng_volume", 32'(ifa.eng_volume), 32'd0);
        chk("mid_rst_eng_flags", {30'd0, ifa.eng_note_pressed, ifa.eng_note_released}, 32'd0);
        chk("mid_rst_b_overrun", 32'(ov_b), 32'd0);
        q.delete();
        for (int v = 0; v < NV; v++) begin
            m_vol[v] = '0; m_pp[v] = 1'b0; m_pr[v] = 1'b0;
        end
        b_next = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        tgt = done_a + 1;
        wait_done(tgt, "post_rst_sweep_done");
        chk("post_rst_sweep_cycle", last_ss - rel_cyc, 32'd39);
        chk("final_a_no_overrun", 32'(ov_a), 32'd0);
        chk("final_b_overrun", 32'(ov_b), 32'd1);
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
